// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end for the 32-bit ALU.
// Decodes ALUOp/funct into the ALU control code, holds operands on the ALU
// for one execute cycle, captures result and zero flag into a response
// register, flags illegal encodings and counts completed responses.
// Optional feature macro: ALU_SEQ_PIPE_EN (accept a new request in the same
// cycle as the response handshake, giving a 2-cycle issue interval).
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_aluop,
  input  logic [5:0]        i_req_funct,
  input  logic [DATA_W-1:0] i_req_a,
  input  logic [DATA_W-1:0] i_req_b,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [3:0]        o_alu_ctl,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic [1:0]        i_alu_zero,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic              o_rsp_zero,
  output logic              o_rsp_err,
  output logic [CNT_W-1:0]  o_op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_alu_a, r_alu_b;
  logic [3:0]          r_alu_ctl;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_zero, r_rsp_err;
  logic [CNT_W-1:0]    r_op_count;

  logic [3:0]          w_dec_ctl;
  logic                w_dec_ok;
  logic                w_req_ready;
  logic                w_accept;
  logic                w_rsp_done;
  // Only bit 0 of the ALU zero flag carries meaning.
  logic                w_unused_zero_hi;

  assign w_unused_zero_hi = i_alu_zero[1];

  // Decode ALUOp/funct into the ALU control code and a legality flag.
  always_comb begin
    w_dec_ctl = 4'b0010;
    w_dec_ok  = 1'b1;
    unique case (i_req_aluop)
      2'b00: w_dec_ctl = 4'b0010;
      2'b01: w_dec_ctl = 4'b0110;
      2'b10: begin
        case (i_req_funct)
          6'b100000: w_dec_ctl = 4'b0010;
          6'b100010: w_dec_ctl = 4'b0110;
          6'b100100: w_dec_ctl = 4'b0000;
          6'b100101: w_dec_ctl = 4'b0001;
          6'b101010: w_dec_ctl = 4'b0111;
          default:   w_dec_ok  = 1'b0;
        endcase
      end
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Ready / handshake qualifiers; RESP may accept only in the pipelined build.
  always_comb begin
    w_req_ready = 1'b0;
    case (r_state)
      IDLE: w_req_ready = 1'b1;
`ifdef ALU_SEQ_PIPE_EN
      RESP: w_req_ready = i_rsp_ready;
`else
      RESP: w_req_ready = 1'b0;
`endif
      default: w_req_ready = 1'b0;
    endcase
  end

  assign w_accept   = i_req_valid && w_req_ready;
  assign w_rsp_done = (r_state == RESP) && i_rsp_ready;

  // Next-state logic: illegal requests skip EXEC and go straight to RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_dec_ok ? EXEC : RESP;
      EXEC: w_next = RESP;
      RESP: begin
        if (w_rsp_done) begin
          if (w_accept) w_next = w_dec_ok ? EXEC : RESP;
          else          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Operand/control capture, response capture and saturating op counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctl    <= 4'b0010;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a <= i_req_a;
        r_alu_b <= i_req_b;
        if (w_dec_ok) begin
          r_alu_ctl <= w_dec_ctl;
        end else begin
          // Illegal: respond immediately, ALU control left as it was.
          r_rsp_result <= '0;
          r_rsp_zero   <= 1'b0;
          r_rsp_err    <= 1'b1;
        end
      end
      if (r_state == EXEC) begin
        r_rsp_result <= i_alu_out;
        r_rsp_zero   <= i_alu_zero[0];
        r_rsp_err    <= 1'b0;
      end
      if (w_rsp_done && (r_op_count != {CNT_W{1'b1}}))
        r_op_count <= r_op_count + 1'b1;
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_ctl    = r_alu_ctl;
  assign o_rsp_valid  = (r_state == RESP);
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;
  assign o_rsp_err    = r_rsp_err;
  assign o_op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the outputs.
module tb_alu_op_sequencer;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
`ifdef ALU_SEQ_PIPE_EN
  localparam int ISSUE = 2;
`else
  localparam int ISSUE = 3;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [1:0]        req_aluop;
  logic [5:0]        req_funct;
  logic [DATA_W-1:0] req_a, req_b;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [3:0]        alu_ctl;
  logic [1:0]        alu_zero;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero, rsp_err;
  logic [CNT_W-1:0]  op_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_aluop(req_aluop), .i_req_funct(req_funct),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctl(alu_ctl),
    .i_alu_out(alu_out), .i_alu_zero(alu_zero),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err),
    .o_op_count(op_count)
  );

  // Reference ALU; bit 1 of the zero flag is deliberately the inverse so a
  // design that samples the wrong bit is caught.
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0111: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = '0;
    endcase
    alu_zero = {(alu_out != '0), (alu_out == '0)};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_aluop = op;
    req_funct = fn;
    req_a     = a;
    req_b     = b;
  endtask

  initial begin
    int resp_n;
    int last_cyc;
    int acc_n;
    logic acc;

    rst = 1'b1; req_valid = 1'b0; req_aluop = 2'b00; req_funct = 6'd0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctl", alu_ctl, 4'b0010);
    chk("rst_op_count", op_count, 0);
    tick();
    chk("idle_rsp_valid", rsp_valid, 0);

    // sub 5-5 -> 0, zero=1
    rsp_ready = 1'b1;
    drive(2'b10, 6'b100010, 32'd5, 32'd5);
    tick();
    req_valid = 1'b0;
    chk("sub_exec_ctl", alu_ctl, 4'b0110);
    chk("sub_exec_a", alu_a, 5);
    chk("sub_exec_ready", req_ready, 0);
    chk("sub_exec_valid", rsp_valid, 0);
    tick();
    chk("sub_rsp_valid", rsp_valid, 1);
    chk("sub_rsp_result", rsp_result, 0);
    chk("sub_rsp_zero", rsp_zero, 1);
    chk("sub_rsp_err", rsp_err, 0);
    tick();
    chk("sub_done_valid", rsp_valid, 0);
    chk("sub_op_count", op_count, 1);

    // slt 3<7 -> 1, held under backpressure
    rsp_ready = 1'b0;
    drive(2'b10, 6'b101010, 32'd3, 32'd7);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("slt_hold_valid%0d", i), rsp_valid, 1);
      chk($sformatf("slt_hold_result%0d", i), rsp_result, 1);
      chk($sformatf("slt_hold_zero%0d", i), rsp_zero, 0);
      chk($sformatf("slt_hold_cnt%0d", i), op_count, 1);
      chk($sformatf("slt_hold_ready%0d", i), req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("slt_done_valid", rsp_valid, 0);
    chk("slt_op_count", op_count, 2);

    // Illegal ALUOp 11: bypasses EXEC, alu_ctl keeps slt code
    drive(2'b11, 6'b100000, 32'd9, 32'd9);
    tick();
    req_valid = 1'b0;
    chk("ill11_valid", rsp_valid, 1);
    chk("ill11_err", rsp_err, 1);
    chk("ill11_result", rsp_result, 0);
    chk("ill11_zero", rsp_zero, 0);
    chk("ill11_ctl", alu_ctl, 4'b0111);
    tick();
    chk("ill11_count", op_count, 3);
    // Illegal funct 000000
    drive(2'b10, 6'b000000, 32'd4, 32'd4);
    tick();
    req_valid = 1'b0;
    chk("illfn_valid", rsp_valid, 1);
    chk("illfn_err", rsp_err, 1);
    chk("illfn_result", rsp_result, 0);
    chk("illfn_ctl", alu_ctl, 4'b0111);
    tick();
    chk("illfn_count", op_count, 4);

    // Reset during EXEC discards the operation
    drive(2'b00, 6'd0, 32'd1, 32'd2);
    tick();
    req_valid = 1'b0;
    chk("rexe_ctl", alu_ctl, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rexe_valid", rsp_valid, 0);
    chk("rexe_ready", req_ready, 1);
    chk("rexe_count", op_count, 0);
    chk("rexe_alu_a", alu_a, 0);
    tick();
    chk("rexe_valid2", rsp_valid, 0);
    chk("rexe_count2", op_count, 0);

    // Back-to-back adds 1+1, 2+2, 3+3 with both sides streaming
    rsp_ready = 1'b1;
    acc_n = 0;
    resp_n = 0;
    last_cyc = 0;
    drive(2'b00, 6'd0, 32'd1, 32'd1);
    for (int cyc = 0; cyc < 30 && resp_n < 3; cyc++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) begin
        acc_n++;
        if (acc_n < 3) drive(2'b00, 6'd0, acc_n + 1, acc_n + 1);
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        resp_n++;
        chk($sformatf("b2b_result%0d", resp_n), rsp_result, 2 * resp_n);
        if (resp_n > 1)
          chk($sformatf("b2b_interval%0d", resp_n), cyc - last_cyc, ISSUE);
        last_cyc = cyc;
      end
    end
    chk("b2b_resp_count", resp_n, 3);
    tick();
    chk("b2b_op_count", op_count, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
